// File: rtl/reg_bank_pkg.sv
// rtl/reg_bank_pkg.sv - shared widths, FSM encoding and port ids for the register bank arbiter
package reg_bank_pkg;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    // True when a byte address falls inside a bank of 'size' bytes.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr, input int size);
        logic [31:0] w_addr32;
        w_addr32 = 32'(addr);
        return w_addr32 < $unsigned(size);
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-way round-robin grant selector
module rr_arbiter_2
    import reg_bank_pkg::*;
(
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_ptr,
    output logic o_grant,
    output logic o_any_req
);

    // Contended requests follow the priority pointer; a lone request wins outright.
    always_comb begin
        o_any_req = i_req_a | i_req_b;
        if (i_req_a && i_req_b) begin
            o_grant = i_ptr;
        end else if (i_req_b) begin
            o_grant = PORT_B;
        end else begin
            o_grant = PORT_A;
        end
    end

endmodule

// File: rtl/reg_bank_arbiter.sv
// rtl/reg_bank_arbiter.sv - two-port arbitrated flip-flop register bank with flat image output
module reg_bank_arbiter
    import reg_bank_pkg::*;
#(
    parameter int REGISTER_BYTE_SIZE = 50
)
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            a_req,
    input  logic                            a_we,
    input  logic [ADDR_W-1:0]               a_addr,
    input  logic [DATA_W-1:0]               a_wdata,
    input  logic                            b_req,
    input  logic                            b_we,
    input  logic [ADDR_W-1:0]               b_addr,
    input  logic [DATA_W-1:0]               b_wdata,
    output logic                            a_ack,
    output logic [DATA_W-1:0]               a_rdata,
    output logic                            a_err,
    output logic                            b_ack,
    output logic [DATA_W-1:0]               b_rdata,
    output logic                            b_err,
    output logic [8*REGISTER_BYTE_SIZE-1:0] Register_Bits
);

    state_t              r_state;
    logic                r_ptr;
    logic                r_port;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_a_ack;
    logic [DATA_W-1:0]   r_a_rdata;
    logic                r_a_err;
    logic                r_b_ack;
    logic [DATA_W-1:0]   r_b_rdata;
    logic                r_b_err;
    logic [DATA_W-1:0]   r_bank [REGISTER_BYTE_SIZE];

    logic                w_grant;
    logic                w_any_req;
    logic                w_in_range;
    logic [DATA_W-1:0]   w_rd_byte;

    rr_arbiter_2 u_rr_arbiter_2 (
        .i_req_a   (a_req),
        .i_req_b   (b_req),
        .i_ptr     (r_ptr),
        .o_grant   (w_grant),
        .o_any_req (w_any_req)
    );

    assign w_in_range = addr_in_range(r_addr, REGISTER_BYTE_SIZE);

    // Read mux over the latched address; out-of-range addresses match nothing and read as zero.
    always_comb begin
        w_rd_byte = '0;
        for (int i = 0; i < REGISTER_BYTE_SIZE; i++) begin
            if (r_addr == ADDR_W'(i)) begin
                w_rd_byte = r_bank[i];
            end
        end
    end

    // Arbitration FSM: latch the winner in IDLE, complete it in ACCESS, pulse ack and rotate priority in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_ptr     <= PORT_A;
            r_port    <= PORT_A;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_a_ack   <= 1'b0;
            r_a_rdata <= '0;
            r_a_err   <= 1'b0;
            r_b_ack   <= 1'b0;
            r_b_rdata <= '0;
            r_b_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_port  <= w_grant;
                        r_we    <= (w_grant == PORT_B) ? b_we    : a_we;
                        r_addr  <= (w_grant == PORT_B) ? b_addr  : a_addr;
                        r_wdata <= (w_grant == PORT_B) ? b_wdata : a_wdata;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (r_port == PORT_A) begin
                        r_a_ack   <= 1'b1;
                        r_a_rdata <= w_in_range ? w_rd_byte : '0;
                        r_a_err   <= ~w_in_range;
                    end else begin
                        r_b_ack   <= 1'b1;
                        r_b_rdata <= w_in_range ? w_rd_byte : '0;
                        r_b_err   <= ~w_in_range;
                    end
                    r_state <= ST_ACK;
                end
                ST_ACK: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_ptr   <= (r_port == PORT_A) ? PORT_B : PORT_A;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_a_ack <= 1'b0;
                    r_b_ack <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bank storage: the latched write lands during ACCESS; out-of-range writes are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REGISTER_BYTE_SIZE; i++) begin
                r_bank[i] <= '0;
            end
        end else if (r_state == ST_ACCESS && r_we && w_in_range) begin
            for (int i = 0; i < REGISTER_BYTE_SIZE; i++) begin
                if (r_addr == ADDR_W'(i)) begin
                    r_bank[i] <= r_wdata;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < REGISTER_BYTE_SIZE; g++) begin : g_image
            assign Register_Bits[8*g +: 8] = r_bank[g];
        end
    endgenerate

    assign a_ack   = r_a_ack;
    assign a_rdata = r_a_rdata;
    assign a_err   = r_a_err;
    assign b_ack   = r_b_ack;
    assign b_rdata = r_b_rdata;
    assign b_err   = r_b_err;

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// tb/tb_reg_bank_arbiter.sv - self-checking bench for reg_bank_arbiter
module tb_reg_bank_arbiter;

    localparam int BYTES = 50;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               a_req, a_we, b_req, b_we;
    logic [14:0]        a_addr, b_addr;
    logic [7:0]         a_wdata, b_wdata;
    logic               a_ack, a_err, b_ack, b_err;
    logic [7:0]         a_rdata, b_rdata;
    logic [8*BYTES-1:0] Register_Bits;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [7:0] m_bank [BYTES];
    bit         m_ptr;

    typedef struct {
        bit          ra;
        bit          awe;
        logic [14:0] aad;
        logic [7:0]  awd;
        bit          rb;
        bit          bwe;
        logic [14:0] bad;
        logic [7:0]  bwd;
        bit          first;
        logic [7:0]  ard;
        bit          aerr;
        logic [7:0]  brd;
        bit          berr;
    } txn_t;

    txn_t tbl[10];

    reg_bank_arbiter #(.REGISTER_BYTE_SIZE(BYTES)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .a_req         (a_req),
        .a_we          (a_we),
        .a_addr        (a_addr),
        .a_wdata       (a_wdata),
        .b_req         (b_req),
        .b_we          (b_we),
        .b_addr        (b_addr),
        .b_wdata       (b_wdata),
        .a_ack         (a_ack),
        .a_rdata       (a_rdata),
        .a_err         (a_err),
        .b_ack         (b_ack),
        .b_rdata       (b_rdata),
        .b_err         (b_err),
        .Register_Bits (Register_Bits)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [8*BYTES-1:0] img();
        logic [8*BYTES-1:0] r;
        for (int i = 0; i < BYTES; i++) r[8*i +: 8] = m_bank[i];
        return r;
    endfunction

    task automatic chk_bits(input string name, input logic [8*BYTES-1:0] exp);
        n_tests++;
        if (Register_Bits !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, Register_Bits, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < BYTES; i++) m_bank[i] = 8'h00;
        m_ptr = 1'b0;
    endfunction

    // One access as the bank sees it: out-of-range -> err, rdata 0, no write.
    function automatic void serve(input bit port, input bit we, input logic [14:0] addr,
                                  input logic [7:0] wd, output logic [7:0] rd, output bit err);
        if (int'(addr) >= BYTES) begin
            err = 1'b1;
            rd  = 8'h00;
        end else begin
            err = 1'b0;
            rd  = m_bank[int'(addr)];
            if (we) m_bank[int'(addr)] = wd;
        end
        m_ptr = ~port;
    endfunction

    // Fills expected fields from the model and advances it (both requests serviced in order).
    function automatic void predict(inout txn_t t);
        t.first = (t.ra && t.rb) ? m_ptr : t.rb;
        for (int k = 0; k < 2; k++) begin
            bit p;
            p = (k == 0) ? t.first : ~t.first;
            if (p == 1'b0 && t.ra) serve(1'b0, t.awe, t.aad, t.awd, t.ard, t.aerr);
            if (p == 1'b1 && t.rb) serve(1'b1, t.bwe, t.bad, t.bwd, t.brd, t.berr);
        end
    endfunction

    function automatic txn_t mk(input bit ra, input bit awe, input logic [14:0] aad, input logic [7:0] awd,
                                input bit rb, input bit bwe, input logic [14:0] bad, input logic [7:0] bwd,
                                input bit first, input logic [7:0] ard, input bit aerr,
                                input logic [7:0] brd, input bit berr);
        txn_t t;
        t.ra = ra; t.awe = awe; t.aad = aad; t.awd = awd;
        t.rb = rb; t.bwe = bwe; t.bad = bad; t.bwd = bwd;
        t.first = first; t.ard = ard; t.aerr = aerr; t.brd = brd; t.berr = berr;
        return t;
    endfunction

    // Drive one (possibly contended) request pair from IDLE and check ack timing and data.
    task automatic run_txn(input string tag, input txn_t t);
        int ta, tb, last;
        ta = t.ra ? ((t.rb && t.first) ? 5 : 2) : -1;
        tb = t.rb ? ((t.ra && !t.first) ? 5 : 2) : -1;
        last = (ta > tb) ? ta : tb;
        a_req = t.ra; a_we = t.awe; a_addr = t.aad; a_wdata = t.awd;
        b_req = t.rb; b_we = t.bwe; b_addr = t.bad; b_wdata = t.bwd;
        for (int c = 1; c <= last + 1; c++) begin
            @(posedge clk); #1;
            chk({tag, " a_ack"}, 32'(a_ack), 32'(c == ta));
            chk({tag, " b_ack"}, 32'(b_ack), 32'(c == tb));
            if (c == ta) begin
                chk({tag, " a_err"}, 32'(a_err), 32'(t.aerr));
                if (!t.awe || t.aerr) chk({tag, " a_rdata"}, 32'(a_rdata), 32'(t.ard));
                a_req = 1'b0;
            end
            if (c == tb) begin
                chk({tag, " b_err"}, 32'(b_err), 32'(t.berr));
                if (!t.bwe || t.berr) chk({tag, " b_rdata"}, 32'(b_rdata), 32'(t.brd));
                b_req = 1'b0;
            end
        end
        chk_bits({tag, " bits"}, img());
    endtask

    // Requests held high continuously (A reads 3, B reads 10) for n total accesses.
    task automatic hold_seq(input string tag, input bit use_a, input bit use_b, input int n);
        bit win[$];
        int ra, rb, k;
        bit w;
        ra = use_a ? (use_b ? n / 2 : n) : 0;
        rb = use_b ? (use_a ? n / 2 : n) : 0;
        for (int i = 0; i < n; i++) begin
            w = (ra > 0 && rb > 0) ? m_ptr : (rb > 0);
            win.push_back(w);
            if (w) rb--; else ra--;
            m_ptr = ~w;
        end
        ra = use_a ? (use_b ? n / 2 : n) : 0;
        rb = use_b ? (use_a ? n / 2 : n) : 0;
        a_req = use_a; a_we = 1'b0; a_addr = 15'd3;
        b_req = use_b; b_we = 1'b0; b_addr = 15'd10;
        for (int c = 1; c <= 3 * n; c++) begin
            bit slot;
            @(posedge clk); #1;
            slot = (c >= 2) && ((c - 2) % 3 == 0);
            k = (c - 2) / 3;
            chk({tag, " a_ack"}, 32'(a_ack), 32'(slot && win[k] == 1'b0));
            chk({tag, " b_ack"}, 32'(b_ack), 32'(slot && win[k] == 1'b1));
            if (slot && win[k] == 1'b0) begin
                chk({tag, " a_rdata"}, 32'(a_rdata), 32'(m_bank[3]));
                ra--;
                if (ra == 0) a_req = 1'b0;
            end
            if (slot && win[k] == 1'b1) begin
                chk({tag, " b_rdata"}, 32'(b_rdata), 32'(m_bank[10]));
                rb--;
                if (rb == 0) b_req = 1'b0;
            end
        end
    endtask

    initial begin
        txn_t t, tm;
        rst_n = 1'b0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst a_ack", 32'(a_ack), 32'd0);
        chk("rst b_ack", 32'(b_ack), 32'd0);
        chk("rst a_rdata", 32'(a_rdata), 32'd0);
        chk("rst b_rdata", 32'(b_rdata), 32'd0);
        chk("rst errs", 32'({a_err, b_err}), 32'd0);
        chk_bits("rst bits", '0);
        rst_n = 1'b1;

        // directed table
        tbl[0] = mk(1,1,15'd3, 8'h5A, 0,0,15'd0,    8'h00, 0, 8'h00,0, 8'h00,0);
        tbl[1] = mk(0,0,15'd0, 8'h00, 1,0,15'd3,    8'h00, 1, 8'h00,0, 8'h5A,0);
        tbl[2] = mk(1,1,15'd10,8'h11, 1,0,15'd10,   8'h00, 0, 8'h00,0, 8'h11,0);
        tbl[3] = mk(1,0,15'd3, 8'h00, 1,1,15'd3,    8'h77, 0, 8'h5A,0, 8'h00,0);
        tbl[4] = mk(1,0,15'd3, 8'h00, 0,0,15'd0,    8'h00, 0, 8'h77,0, 8'h00,0);
        tbl[5] = mk(1,0,15'd10,8'h00, 1,0,15'd3,    8'h00, 1, 8'h11,0, 8'h77,0);
        tbl[6] = mk(0,0,15'd0, 8'h00, 1,1,15'd50,   8'hFF, 1, 8'h00,0, 8'h00,1);
        tbl[7] = mk(1,1,15'd49,8'h81, 0,0,15'd0,    8'h00, 0, 8'h00,0, 8'h00,0);
        tbl[8] = mk(1,0,15'd49,8'h00, 0,0,15'd0,    8'h00, 0, 8'h81,0, 8'h00,0);
        tbl[9] = mk(0,0,15'd0, 8'h00, 1,0,15'h7FFF, 8'h00, 1, 8'h00,0, 8'h00,1);
        for (int i = 0; i < 10; i++) begin
            tm = tbl[i];
            predict(tm);
            run_txn($sformatf("tbl%0d", i), tbl[i]);
        end
        chk("bit392", 32'(Register_Bits[392]), 32'd1);
        chk("bit399", 32'(Register_Bits[399]), 32'd1);
        chk("byte49", 32'(Register_Bits[399:392]), 32'h81);

        // A alone held for four accesses: acks at +2,+5,+8,+11
        hold_seq("holdA", 1'b1, 1'b0, 4);
        chk("b_err retained", 32'(b_err), 32'd1);
        // both held: grants alternate
        hold_seq("holdAB", 1'b1, 1'b1, 4);

        // randomized traffic against the model
        for (int i = 0; i < 40; i++) begin
            t.ra  = $urandom_range(0, 1);
            t.rb  = $urandom_range(0, 1);
            if (!t.ra && !t.rb) t.ra = 1'b1;
            t.awe = $urandom_range(0, 1);
            t.bwe = $urandom_range(0, 1);
            t.aad = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(50, 32767)) : 15'($urandom_range(0, 49));
            t.bad = ($urandom_range(0, 7) == 0) ? 15'($urandom_range(50, 32767)) : 15'($urandom_range(0, 49));
            if ($urandom_range(0, 2) == 0) t.bad = t.aad;
            t.awd = 8'($urandom);
            t.bwd = 8'($urandom);
            predict(t);
            run_txn($sformatf("rnd%0d", i), t);
        end

        // reset while an A write to addr 0 sits in ACCESS
        a_req = 1'b1; a_we = 1'b1; a_addr = 15'd0; a_wdata = 8'hAA;
        @(posedge clk); #1;
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0;
        #1;
        chk("midrst acks", 32'({a_ack, b_ack}), 32'd0);
        chk("midrst rdata", 32'({a_rdata, b_rdata}), 32'd0);
        chk("midrst errs", 32'({a_err, b_err}), 32'd0);
        chk_bits("midrst bits", '0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("postrst no ack", 32'({a_ack, b_ack}), 32'd0);
        end
        chk("byte0 clear", 32'(Register_Bits[7:0]), 32'd0);
        // first contended request after reset goes to A
        t = mk(1,1,15'd0,8'h3C, 1,0,15'd0,8'h00, 0, 8'h00,0, 8'h3C,0);
        tm = t;
        predict(tm);
        run_txn("postrst", t);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
